// File: rtl/orb_pkg.sv
// Shared constants, source indices and slot entry type for the orbit-frame write arbiter.
package orb_pkg;

  localparam int ORB_AW   = 11;
  localparam int ORB_DW   = 12;
  localparam int ORB_NSRC = 5;
  localparam int ORB_PW   = $clog2(ORB_NSRC);

  localparam int SRC_FAST1 = 0;
  localparam int SRC_FAST2 = 1;
  localparam int SRC_SLOW1 = 2;
  localparam int SRC_SLOW2 = 3;
  localparam int SRC_TEMP  = 4;

  // One buffered write: bank is the sw value seen when the strobe was captured.
  typedef struct packed {
    logic              valid;
    logic              bank;
    logic [ORB_AW-1:0] addr;
    logic [ORB_DW-1:0] data;
  } orb_slot_t;

  // Round-robin pointer successor, wrapping at the last source.
  function automatic logic [ORB_PW-1:0] orb_next_ptr(input logic [ORB_PW-1:0] k);
    return (k == ORB_PW'(ORB_NSRC - 1)) ? '0 : k + 1'b1;
  endfunction

endpackage

// File: rtl/orb_rr_pick.sv
// Combinational round-robin picker: first valid slot at or above the pointer, modulo N.
module orb_rr_pick
  import orb_pkg::*;
#(
  parameter int N  = ORB_NSRC,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the farthest offset down so the nearest valid slot is the last one written.
  always_comb begin
    int          k;
    logic [PW-1:0] w_k;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    k       = 0;
    w_k     = '0;
    for (int j = N - 1; j >= 0; j--) begin
      k = int'(i_ptr) + j;
      if (k >= N) k = k - N;
      w_k = PW'(k);
      if (i_valid[w_k]) begin
        o_grant      = '0;
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/orb_wr_arbiter.sv
// Buffers one write per packer source and grants the shared bank-steered RAM port round-robin.
module orb_wr_arbiter
  import orb_pkg::*;
#(
  parameter int N_SRC = ORB_NSRC,
  parameter int AW    = ORB_AW,
  parameter int DW    = ORB_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    req,
  input  logic [N_SRC*AW-1:0] addr_in,
  input  logic [N_SRC*DW-1:0] data_in,
  input  logic                sw,
  output logic [AW-1:0]       wraddr,
  output logic [DW-1:0]       wdata,
  output logic                wren1,
  output logic                wren2,
  output logic [N_SRC-1:0]    pending,
  output logic [N_SRC-1:0]    ovf,
  input  logic                ovf_clr
);

  localparam int PW = ORB_PW;

  orb_slot_t        r_slot [N_SRC];
  logic [N_SRC-1:0] r_ovf;
  logic [PW-1:0]    r_ptr;
  logic [AW-1:0]    r_wraddr;
  logic [DW-1:0]    r_wdata;
  logic             r_wren1;
  logic             r_wren2;

  logic [AW-1:0]    w_addr [N_SRC];
  logic [DW-1:0]    w_data [N_SRC];
  logic [N_SRC-1:0] w_valid;
  logic [N_SRC-1:0] w_grant;
  logic [N_SRC-1:0] w_ovf_set;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  orb_slot_t        w_sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
      assign w_addr[gi]  = addr_in[gi*AW +: AW];
      assign w_data[gi]  = data_in[gi*DW +: DW];
      assign w_valid[gi] = r_slot[gi].valid;
    end
  endgenerate

  orb_rr_pick #(.N(N_SRC), .PW(PW)) u_pick (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A strobe into an occupied slot that is not draining this edge is lost.
  assign w_ovf_set = req & w_valid & ~w_grant;
  assign w_sel     = r_slot[w_idx];

  // Slot capture/drain and sticky overflow; a new overflow wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) r_slot[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (req[i] && (!r_slot[i].valid || w_grant[i])) begin
          r_slot[i] <= '{valid: 1'b1, bank: sw, addr: w_addr[i], data: w_data[i]};
        end else if (w_grant[i]) begin
          r_slot[i].valid <= 1'b0;
        end
      end
      r_ovf <= (r_ovf & {N_SRC{~ovf_clr}}) | w_ovf_set;
    end
  end

  // Write port register: one granted entry per clock, steered by its captured bank tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr    <= '0;
      r_wraddr <= '0;
      r_wdata  <= '0;
      r_wren1  <= 1'b0;
      r_wren2  <= 1'b0;
    end else if (w_any) begin
      r_ptr    <= orb_next_ptr(w_idx);
      r_wraddr <= w_sel.addr;
      r_wdata  <= w_sel.data;
      r_wren1  <= w_sel.bank;
      r_wren2  <= ~w_sel.bank;
    end else begin
      r_wren1  <= 1'b0;
      r_wren2  <= 1'b0;
    end
  end

  assign wraddr  = r_wraddr;
  assign wdata   = r_wdata;
  assign wren1   = r_wren1;
  assign wren2   = r_wren2;
  assign pending = w_valid;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Bench for orb_wr_arbiter: directed table, hand sequences and random traffic vs a reference model.
module tb_orb_wr_arbiter;

  localparam int N  = 5;
  localparam int AW = 11;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic            sw = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [AW-1:0]   wraddr;
  logic [DW-1:0]   wdata;
  logic            wren1, wren2;
  logic [N-1:0]    pending, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  orb_wr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .data_in(data_in),
    .sw(sw), .wraddr(wraddr), .wdata(wdata), .wren1(wren1), .wren2(wren2),
    .pending(pending), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a set of buffered writes plus a rotating search start.
  bit       m_v [N];
  bit       m_b [N];
  int       m_a [N];
  int       m_d [N];
  int       m_ptr;
  bit [N-1:0] m_ovf;
  bit       m_w1, m_w2;
  int       m_wa, m_wd;
  int       src_a [N];
  int       src_d [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_b[i] = 0; m_a[i] = 0; m_d[i] = 0; end
    m_ptr = 0; m_ovf = '0; m_w1 = 0; m_w2 = 0; m_wa = 0; m_wd = 0;
  endtask

  task automatic model_edge();
    int g;
    bit [N-1:0] set;
    g = -1;
    set = '0;
    for (int j = 0; j < N; j++) if (g < 0 && m_v[(m_ptr + j) % N]) g = (m_ptr + j) % N;
    if (g >= 0) begin
      m_w1 = m_b[g]; m_w2 = !m_b[g]; m_wa = m_a[g]; m_wd = m_d[g];
      m_ptr = (g + 1) % N;
    end else begin
      m_w1 = 0; m_w2 = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (!m_v[i] || g == i) begin
          m_v[i] = 1; m_b[i] = sw; m_a[i] = src_a[i]; m_d[i] = src_d[i];
        end else begin
          set[i] = 1'b1;
        end
      end else if (g == i) begin
        m_v[i] = 0;
      end
    end
    m_ovf = (ovf_clr ? '0 : m_ovf) | set;
  endtask

  function automatic logic [34:0] dut_vec();
    return {wren1, wren2, wraddr, wdata, pending, ovf};
  endfunction

  function automatic logic [34:0] mk_vec(bit w1, bit w2, int wa, int wd, bit [N-1:0] p, bit [N-1:0] o);
    return {w1, w2, AW'(wa), DW'(wd), p, o};
  endfunction

  task automatic check(string name, logic [34:0] act, logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got w1=%0b w2=%0b addr=%0d data=%h pend=%b ovf=%b, want w1=%0b w2=%0b addr=%0d data=%h pend=%b ovf=%b",
               name, act[34], act[33], act[32:22], act[21:10], act[9:5], act[4:0],
               exp[34], exp[33], exp[32:22], exp[21:10], exp[9:5], exp[4:0]);
    end
  endtask

  function automatic logic [34:0] model_vec();
    bit [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_v[i];
    return mk_vec(m_w1, m_w2, m_wa, m_wd, p, m_ovf);
  endfunction

  task automatic set_src(int i, int a, int d);
    src_a[i] = a & 'h7FF;
    src_d[i] = d & 'hFFF;
    addr_in[i*AW +: AW] = AW'(src_a[i]);
    data_in[i*DW +: DW] = DW'(src_d[i]);
  endtask

  task automatic drive(bit [N-1:0] r, bit s, bit c, int abase, int dbase);
    @(negedge clk);
    req = r; sw = s; ovf_clr = c;
    for (int i = 0; i < N; i++) set_src(i, abase + i, dbase + i);
  endtask

  task automatic cycle(string name);
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; req = '0; ovf_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    cycle("post_reset_idle");
  endtask

  typedef struct {
    bit         do_rst;
    bit [N-1:0] req;
    bit         sw;
    bit         clr;
    int         abase;
    int         dbase;
    bit         w1;
    bit         w2;
    int         wa;
    int         wd;
    bit [N-1:0] pend;
    bit [N-1:0] ovf;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int prev_src;
    int cur_src;
    for (int i = 0; i < N; i++) begin src_a[i] = 0; src_d[i] = 0; end
    model_reset();

    // single write, full collision, overflow + clear, bank retag
    tbl[0]  = '{0, 5'b00100, 0, 0, 829, 'hABA, 0, 0, 0,   0,      5'b00100, 5'b00000};
    tbl[1]  = '{0, 5'b00000, 0, 0, 0,   0,     0, 1, 831, 'hABC,  5'b00000, 5'b00000};
    tbl[2]  = '{0, 5'b00000, 0, 0, 0,   0,     0, 0, 831, 'hABC,  5'b00000, 5'b00000};
    tbl[3]  = '{1, 5'b11111, 1, 0, 0,   16,    0, 0, 0,   0,      5'b11111, 5'b00000};
    tbl[4]  = '{0, 5'b00000, 1, 0, 0,   0,     1, 0, 0,   16,     5'b11110, 5'b00000};
    tbl[5]  = '{0, 5'b00000, 1, 0, 0,   0,     1, 0, 1,   17,     5'b11100, 5'b00000};
    tbl[6]  = '{0, 5'b00000, 1, 0, 0,   0,     1, 0, 2,   18,     5'b11000, 5'b00000};
    tbl[7]  = '{0, 5'b00000, 1, 0, 0,   0,     1, 0, 3,   19,     5'b10000, 5'b00000};
    tbl[8]  = '{0, 5'b00000, 1, 0, 0,   0,     1, 0, 4,   20,     5'b00000, 5'b00000};
    tbl[9]  = '{0, 5'b00000, 1, 0, 0,   0,     0, 0, 4,   20,     5'b00000, 5'b00000};
    tbl[10] = '{1, 5'b11111, 0, 0, 100, 'h200, 0, 0, 0,   0,      5'b11111, 5'b00000};
    tbl[11] = '{0, 5'b10000, 0, 0, 300, 'h300, 0, 1, 100, 'h200,  5'b11110, 5'b10000};
    tbl[12] = '{0, 5'b00000, 0, 0, 0,   0,     0, 1, 101, 'h201,  5'b11100, 5'b10000};
    tbl[13] = '{0, 5'b00000, 0, 0, 0,   0,     0, 1, 102, 'h202,  5'b11000, 5'b10000};
    tbl[14] = '{0, 5'b00000, 0, 0, 0,   0,     0, 1, 103, 'h203,  5'b10000, 5'b10000};
    tbl[15] = '{0, 5'b00000, 0, 0, 0,   0,     0, 1, 104, 'h204,  5'b00000, 5'b10000};
    tbl[16] = '{0, 5'b00000, 0, 1, 0,   0,     0, 0, 104, 'h204,  5'b00000, 5'b00000};
    tbl[17] = '{1, 5'b00001, 0, 0, 50,  'h050, 0, 0, 0,   0,      5'b00001, 5'b00000};
    tbl[18] = '{0, 5'b00000, 1, 0, 0,   0,     0, 1, 50,  'h050,  5'b00000, 5'b00000};

    // reset held with every input active
    rst = 0; req = '1; sw = 1; ovf_clr = 0;
    for (int i = 0; i < N; i++) set_src(i, 7 + i, 9 + i);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("reset_hold", dut_vec(), mk_vec(0, 0, 0, 0, '0, '0));
    end
    @(negedge clk);
    req = '0; rst = 1;
    cycle("reset_release");

    for (int r = 0; r < 19; r++) begin
      if (tbl[r].do_rst) do_reset();
      drive(tbl[r].req, tbl[r].sw, tbl[r].clr, tbl[r].abase, tbl[r].dbase);
      cycle($sformatf("row%0d_model", r));
      check($sformatf("row%0d", r), dut_vec(),
            mk_vec(tbl[r].w1, tbl[r].w2, tbl[r].wa, tbl[r].wd, tbl[r].pend, tbl[r].ovf));
      $display("row %0d req=%b sw=%0b -> w1=%0b w2=%0b addr=%0d data=%h pend=%b ovf=%b",
               r, tbl[r].req, tbl[r].sw, wren1, wren2, wraddr, wdata, pending, ovf);
    end

    // streaming: one source every cycle never overflows
    do_reset();
    for (int n = 0; n < 20; n++) begin
      drive(5'b00010, 1, 0, n - 1, 'h100 + n - 1);
      cycle("stream_model");
      if (n >= 1)
        check("stream_write", dut_vec(), mk_vec(1, 0, n - 1, 'h100 + n - 1, 5'b00010, 5'b00000));
    end
    drive(5'b00000, 1, 0, 0, 0);
    cycle("stream_tail_model");
    check("stream_tail", dut_vec(), mk_vec(1, 0, 19, 'h113, 5'b00000, 5'b00000));

    // two sources streaming: grants must alternate between 1 and 3
    prev_src = -1;
    for (int n = 0; n < 12; n++) begin
      drive(5'b01010, 1, 0, 0, 0);
      set_src(1, n, n);
      set_src(3, 'h400 | n, 'h400 | n);
      cycle("dual_model");
      if (wren1) begin
        cur_src = wraddr[10] ? 3 : 1;
        if (prev_src >= 0) begin
          n_cmp++;
          if (cur_src == prev_src) begin
            n_bad++;
            $display("FAIL dual_alternate: got source %0d twice, want alternation", cur_src);
          end
        end
        prev_src = cur_src;
      end
    end

    // reset mid-operation drops everything at once
    do_reset();
    drive(5'b11111, 0, 0, 60, 'h600);
    cycle("midrst_fill");
    drive(5'b00000, 0, 0, 0, 0);
    cycle("midrst_one");
    @(negedge clk);
    req = '1; rst = 0;
    model_reset();
    #1;
    check("midrst_async", dut_vec(), mk_vec(0, 0, 0, 0, '0, '0));
    cycle("midrst_hold");
    @(negedge clk);
    req = '0; rst = 1;
    cycle("midrst_release");

    // random traffic vs model
    for (int n = 0; n < 400; n++) begin
      drive(N'($urandom & $urandom), 1'($urandom), ($urandom % 16) == 0,
            int'($urandom % 2048), int'($urandom % 4096));
      if ($urandom % 150 == 0) begin
        rst = 0;
        model_reset();
      end else begin
        rst = 1;
      end
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
